// File: rtl/phy_tx_pcs.sv
// 100BASE-X style transmit PCS: MII nibbles -> 4B5B code groups -> serial line.
// A five-slot counter paces the MAC via o_nib_stb; each strobe edge loads one
// code group, and the other four edges shift it out MSB first. When P_NRZI is
// set the line is NRZI coded (a 1 toggles the line, a 0 holds it).
module phy_tx_pcs #(
  parameter bit P_NRZI = 1'b1
) (
  input  logic       i_clk,
  input  logic       i_res_n,
  input  logic       i_mii_tx_en,
  input  logic [3:0] i_mii_tx_data,
  output logic       o_nib_stb,
  output logic       o_tx_active,
  output logic       o_sfp_tx
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_J,
    S_K,
    S_DATA,
    S_T,
    S_R
  } state_t;

  localparam logic [4:0] CG_I = 5'b11111;
  localparam logic [4:0] CG_J = 5'b11000;
  localparam logic [4:0] CG_K = 5'b10001;
  localparam logic [4:0] CG_T = 5'b01101;
  localparam logic [4:0] CG_R = 5'b00111;

  logic [2:0] slot_cnt;
  state_t     state;
  state_t     state_nxt;
  logic [4:0] shreg;
  logic [4:0] code_nxt;

  function automatic logic [4:0] enc_4b5b(input logic [3:0] nib);
    logic [4:0] code;
    case (nib)
      4'h0:    code = 5'b11110;
      4'h1:    code = 5'b01001;
      4'h2:    code = 5'b10100;
      4'h3:    code = 5'b10101;
      4'h4:    code = 5'b01010;
      4'h5:    code = 5'b01011;
      4'h6:    code = 5'b01110;
      4'h7:    code = 5'b01111;
      4'h8:    code = 5'b10010;
      4'h9:    code = 5'b10011;
      4'hA:    code = 5'b10110;
      4'hB:    code = 5'b10111;
      4'hC:    code = 5'b11010;
      4'hD:    code = 5'b11011;
      4'hE:    code = 5'b11100;
      default: code = 5'b11101;
    endcase
    return code;
  endfunction

  // Slot counter 0..4; slot 4 is the nibble strobe and the load edge.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others, independent of block ordering.
  always_ff @(posedge i_clk or negedge i_res_n) begin
    if (!i_res_n) begin
      slot_cnt <= 3'd0;
    end else if (slot_cnt == 3'd4) begin
      slot_cnt <= 3'd0;
    end else begin
      slot_cnt <= slot_cnt + 3'd1;
    end
  end

  assign o_nib_stb = (slot_cnt == 3'd4);

  // Framing state advances only on load edges.
  always_ff @(posedge i_clk or negedge i_res_n) begin
    if (!i_res_n) begin
      state <= S_IDLE;
    end else if (o_nib_stb) begin
      state <= state_nxt;
    end
  end

  // Next state and the code group to load on the coming strobe edge.
  // NOTE: both outputs get a default before the case so no path leaves them
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    code_nxt  = CG_I;
    case (state)
      S_IDLE: begin
        if (i_mii_tx_en) begin
          state_nxt = S_J;
          code_nxt  = CG_J;
        end
      end
      S_J: begin
        state_nxt = S_K;
        code_nxt  = CG_K;
      end
      S_K, S_DATA: begin
        if (i_mii_tx_en) begin
          state_nxt = S_DATA;
          code_nxt  = enc_4b5b(i_mii_tx_data);
        end else begin
          state_nxt = S_T;
          code_nxt  = CG_T;
        end
      end
      S_T: begin
        state_nxt = S_R;
        code_nxt  = CG_R;
      end
      S_R: begin
        state_nxt = S_IDLE;
        code_nxt  = CG_I;
      end
      default: begin
        state_nxt = S_IDLE;
        code_nxt  = CG_I;
      end
    endcase
  end

  // Code group shifter: load on the strobe, otherwise shift left filling
  // with ones so the line keeps carrying idle until the first load.
  always_ff @(posedge i_clk or negedge i_res_n) begin
    if (!i_res_n) begin
      shreg <= CG_I;
    end else if (o_nib_stb) begin
      shreg <= code_nxt;
    end else begin
      shreg <= {shreg[3:0], 1'b1};
    end
  end

  // Transmit activity flag follows whatever group is being loaded.
  always_ff @(posedge i_clk or negedge i_res_n) begin
    if (!i_res_n) begin
      o_tx_active <= 1'b0;
    end else if (o_nib_stb) begin
      o_tx_active <= (state_nxt != S_IDLE);
    end
  end

  // Serial line flop: NRZI toggle on a one, or the raw code bit.
  always_ff @(posedge i_clk or negedge i_res_n) begin
    if (!i_res_n) begin
      o_sfp_tx <= 1'b0;
    end else if (P_NRZI) begin
      o_sfp_tx <= o_sfp_tx ^ shreg[4];
    end else begin
      o_sfp_tx <= shreg[4];
    end
  end

endmodule

// File: tb/tb_phy_tx_pcs.sv
// Bench for phy_tx_pcs. Two instances share the MII stimulus: one emits raw
// code bits, the other NRZI. Stimulus is a slot-by-slot schedule built from
// frame descriptions; the expected code group for each slot comes from the
// frame-level rule J,K,enc(nibbles[2..]),T,R,I. The NRZI line is decoded and
// 5B-to-4B mapped back into nibbles.
module tb_phy_tx_pcs;

  localparam logic [4:0] G_I = 5'b11111;
  localparam logic [4:0] G_J = 5'b11000;
  localparam logic [4:0] G_K = 5'b10001;
  localparam logic [4:0] G_T = 5'b01101;
  localparam logic [4:0] G_R = 5'b00111;

  logic [4:0] enc_tbl [16] = '{
    5'b11110, 5'b01001, 5'b10100, 5'b10101, 5'b01010, 5'b01011, 5'b01110, 5'b01111,
    5'b10010, 5'b10011, 5'b10110, 5'b10111, 5'b11010, 5'b11011, 5'b11100, 5'b11101
  };

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [3:0] dat;
  logic       stb_r, act_r, line_r;
  logic       stb_n, act_n, line_n;

  phy_tx_pcs #(.P_NRZI(1'b0)) dut_raw (
    .i_clk(clk), .i_res_n(rst_n), .i_mii_tx_en(en), .i_mii_tx_data(dat),
    .o_nib_stb(stb_r), .o_tx_active(act_r), .o_sfp_tx(line_r)
  );

  phy_tx_pcs #(.P_NRZI(1'b1)) dut_nrzi (
    .i_clk(clk), .i_res_n(rst_n), .i_mii_tx_en(en), .i_mii_tx_data(dat),
    .o_nib_stb(stb_n), .o_tx_active(act_n), .o_sfp_tx(line_n)
  );

  // 125 MHz bit clock
  always #4 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Slot schedule: inputs presented at each load edge and the group it loads.
  bit         sch_en  [$];
  logic [3:0] sch_dat [$];
  logic [4:0] sch_grp [$];
  logic [3:0] exp_nib [$];
  logic [3:0] cur_nibs[$];
  logic       dbits   [$];

  task automatic clear_sched();
    sch_en.delete(); sch_dat.delete(); sch_grp.delete(); exp_nib.delete();
  endtask

  task automatic add_slot(input bit e, input logic [3:0] d, input logic [4:0] g);
    sch_en.push_back(e); sch_dat.push_back(d); sch_grp.push_back(g);
  endtask

  task automatic add_idle(input int cnt);
    for (int i = 0; i < cnt; i++) add_slot(1'b0, 4'($urandom), G_I);
  endtask

  // Frame of cur_nibs; tail_en drives en during the R and I slots, where it
  // must be ignored.
  task automatic add_frame(input bit tail_en);
    int n = cur_nibs.size();
    for (int i = 0; i < n; i++) begin
      logic [4:0] g;
      if (i == 0) g = G_J;
      else if (i == 1) g = G_K;
      else begin
        g = enc_tbl[cur_nibs[i]];
        exp_nib.push_back(cur_nibs[i]);
      end
      add_slot(1'b1, cur_nibs[i], g);
    end
    if (n == 1) add_slot(1'b0, 4'($urandom), G_K);
    add_slot(1'b0, 4'($urandom), G_T);
    add_slot(tail_en, 4'($urandom), G_R);
    add_slot(tail_en, 4'($urandom), G_I);
  endtask

  task automatic rand_frame(input int n, input bit tail_en);
    cur_nibs.delete();
    for (int i = 0; i < n; i++) cur_nibs.push_back(4'($urandom));
    add_frame(tail_en);
  endtask

  // Edge n counts rising edges since reset release; load edges are 5,10,...
  function automatic logic exp_bit(input int n);
    int m = (n - 1) / 5;
    int j = n - 5 * m;
    logic [4:0] g;
    if (m == 0) return 1'b1;
    g = sch_grp[m - 1];
    return g[5 - j];
  endfunction

  function automatic logic exp_active(input int n);
    int m = n / 5;
    if (m == 0) return 1'b0;
    return sch_grp[m - 1] != G_I;
  endfunction

  // Present scheduled inputs before a load edge, junk before any other edge.
  task automatic drive(input int k);
    if (k % 5 == 0) begin
      int s = k / 5 - 1;
      if (s < sch_grp.size()) begin
        en  = sch_en[s];
        dat = sch_dat[s];
      end else begin
        en  = 1'b0;
        dat = 4'($urandom);
      end
    end else begin
      en  = 1'($urandom);
      dat = 4'($urandom);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_line_raw", line_r, 1'b0);
    check("rst_line_nrzi", line_n, 1'b0);
    check("rst_active", act_n, 1'b0);
    check("rst_stb", stb_r, 1'b0);
    repeat (3) @(negedge clk);
    check("rst_hold_line", line_n, 1'b0);
    check("rst_hold_active", act_r, 1'b0);
    rst_n = 1'b1;
  endtask

  // Decode the NRZI bit stream into groups and data nibbles.
  task automatic decode_check(input int n_edges);
    logic [3:0] rec[$];
    bit in_data = 1'b0;
    for (int k = 0; 5 * k + 10 <= n_edges; k++) begin
      int b = 5 * k + 5;
      logic [4:0] g = {dbits[b], dbits[b+1], dbits[b+2], dbits[b+3], dbits[b+4]};
      check($sformatf("nrzi_grp@%0d", k), g, sch_grp[k]);
      if (g == G_K) in_data = 1'b1;
      else if (g == G_T) in_data = 1'b0;
      else if (in_data) begin
        logic [3:0] nib = 4'bxxxx;
        for (int v = 0; v < 16; v++) if (enc_tbl[v] == g) nib = 4'(v);
        rec.push_back(nib);
      end
    end
    check("nib_count", rec.size(), exp_nib.size());
    for (int i = 0; i < rec.size() && i < exp_nib.size(); i++)
      check($sformatf("nib@%0d", i), rec[i], exp_nib[i]);
  endtask

  task automatic run(input int n_edges, input bit decode);
    logic prev_line = 1'b0;
    logic model_line = 1'b0;
    dbits.delete();
    drive(1);
    for (int n = 1; n <= n_edges; n++) begin
      logic eb;
      @(posedge clk);
      #1;
      eb = exp_bit(n);
      model_line = model_line ^ eb;
      check($sformatf("raw_bit@%0d", n), line_r, eb);
      check($sformatf("nrzi_line@%0d", n), line_n, model_line);
      check($sformatf("stb_raw@%0d", n), stb_r, n % 5 == 4);
      check($sformatf("stb_nrzi@%0d", n), stb_n, n % 5 == 4);
      check($sformatf("active_raw@%0d", n), act_r, exp_active(n));
      check($sformatf("active_nrzi@%0d", n), act_n, exp_active(n));
      dbits.push_back(line_n ^ prev_line);
      prev_line = line_n;
      drive(n + 1);
    end
    if (decode) decode_check(n_edges);
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    dat   = 4'h0;

    // Idle, fixed frame, single-nibble frame, en held through R/I, random frames
    do_reset();
    clear_sched();
    add_idle(20);
    cur_nibs = '{4'h5, 4'h5, 4'h5, 4'h5, 4'h5, 4'h5, 4'h5, 4'hD, 4'h1, 4'h2, 4'hF};
    add_frame(1'b0);
    add_idle(2);
    cur_nibs = '{4'h9};
    add_frame(1'b0);
    add_idle(3);
    rand_frame(2, 1'b1);
    rand_frame(3, 1'b1);
    add_idle(1);
    repeat (12) begin
      rand_frame($urandom_range(1, 16), 1'($urandom_range(0, 1)));
      add_idle($urandom_range(0, 3));
    end
    add_idle(4);
    run(5 * sch_grp.size() + 4, 1'b1);

    // Reset pulsed mid-frame while data groups are going out
    do_reset();
    clear_sched();
    rand_frame(8, 1'b0);
    add_idle(2);
    run(22, 1'b0);
    check("pre_abort_active", act_r, 1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_line_raw", line_r, 1'b0);
    check("abort_line_nrzi", line_n, 1'b0);
    check("abort_active_raw", act_r, 1'b0);
    check("abort_active_nrzi", act_n, 1'b0);
    check("abort_stb", stb_n, 1'b0);
    do_reset();
    clear_sched();
    add_idle(12);
    run(5 * 12 + 4, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
